// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the pulse spacer and the async pulse synchronizer benches.
// Holds the spacer FSM state type, default sizing constants and a sizing helper.
package pulse_sync_pkg;

  localparam int PULSE_MIN_GAP_DFLT = 3;
  localparam int PULSE_CNT_W_DFLT   = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } pulse_state_e;

  // Width of a down-counter that must hold the value min_gap.
  function automatic int gap_cnt_width(input int min_gap);
    return (min_gap < 2) ? 1 : $clog2(min_gap + 1);
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with full/empty flags; simultaneous inc and dec cancel.
// Never wraps; a decrement request while empty is flagged by an assertion.
module sat_updown_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign full  = (cnt_q == {W{1'b1}});
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (latch).
    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10:   if (!full)  cnt_d = cnt_q + 1'b1;
      2'b01:   if (!empty) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  underflow_chk: assert property (@(posedge clk) disable iff (rst) !(dec && !inc && empty))
    else $error("sat_updown_cnt: decrement requested while empty");

endmodule

// File: rtl/pulse_spacer.sv
// Re-emits single-cycle event pulses one at a time with at least MIN_GAP idle
// cycles between outputs, buffering up to 2^CNT_W-1 pending events.
module pulse_spacer
  import pulse_sync_pkg::*;
#(
  parameter int MIN_GAP = PULSE_MIN_GAP_DFLT,
  parameter int CNT_W   = PULSE_CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pulse,
  input  logic             clr_ovf,
  output logic             out_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam int               GAP_W    = gap_cnt_width(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);

  if (MIN_GAP < 1) begin : g_bad_min_gap
    $fatal(1, "pulse_spacer: MIN_GAP must be >= 1");
  end

  pulse_state_e     state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             out_pulse_q, out_pulse_d;
  logic             ovf_q, ovf_d;

  logic issue;
  logic drop;
  logic accept;
  logic pend_full;
  logic pend_empty;

  always_comb begin
    issue  = (state_q == ST_IDLE) && (!pend_empty || in_pulse);
    // Only a full counter with no simultaneous issue loses the incoming event.
    drop   = in_pulse && pend_full && !issue;
    accept = in_pulse && !drop;

    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    out_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          out_pulse_d = 1'b1;
          gap_cnt_d   = GAP_LOAD;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == GAP_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      out_pulse_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      out_pulse_q <= out_pulse_d;
      ovf_q       <= ovf_d;
    end
  end

  // An input accepted in the same cycle as an issue cancels out, so a direct
  // pass-through event never touches the counter.
  sat_updown_cnt #(
    .W (CNT_W)
  ) u_pend_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .dec   (issue),
    .cnt   (pending),
    .full  (pend_full),
    .empty (pend_empty)
  );

  assign out_pulse = out_pulse_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q == ST_GAP) || !pend_empty;

endmodule

// File: tb/tb_pulse_spacer.sv
// Self-checking bench for pulse_spacer: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based reference model.
module tb_pulse_spacer;

  localparam int MIN_GAP  = 3;
  localparam int CNT_W    = 4;
  localparam int PEND_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_pulse;
  logic             clr_ovf;
  logic             out_pulse;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: events waiting, cycle index, and the edge of the last emission.
  int m_pend;
  int m_cyc;
  int m_last_issue;
  bit m_out;
  bit m_ovf;

  pulse_spacer #(
    .MIN_GAP (MIN_GAP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pulse  (in_pulse),
    .clr_ovf   (clr_ovf),
    .out_pulse (out_pulse),
    .pending   (pending),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend       = 0;
    m_out        = 1'b0;
    m_ovf        = 1'b0;
    m_last_issue = m_cyc - 1000;
  endtask

  function automatic bit model_ready();
    return (m_cyc - m_last_issue) > MIN_GAP;
  endfunction

  // Called just after a rising edge: drive inputs, check the current cycle,
  // then advance the model across the next edge.
  task automatic tick(input logic i, input logic c);
    bit issue, drop, m_busy;
    in_pulse = i;
    clr_ovf  = c;
    m_busy   = (m_pend != 0) || ((m_cyc - m_last_issue) <= MIN_GAP);
    check($sformatf("out_pulse@%0d", m_cyc), 32'(out_pulse), 32'(m_out));
    check($sformatf("pending@%0d", m_cyc),   32'(pending),   32'(m_pend));
    check($sformatf("busy@%0d", m_cyc),      32'(busy),      32'(m_busy));
    check($sformatf("overflow@%0d", m_cyc),  32'(overflow),  32'(m_ovf));
    @(posedge clk);
    issue = model_ready() && (m_pend != 0 || i);
    drop  = i && (m_pend == PEND_MAX) && !issue;
    if (i && !drop) m_pend++;
    if (issue) begin
      m_pend--;
      m_last_issue = m_cyc;
    end
    if (drop)   m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    m_out = issue;
    m_cyc++;
    #1;
  endtask

  initial begin
    m_cyc    = 0;
    rst      = 1'b1;
    in_pulse = 1'b0;
    clr_ovf  = 1'b0;
    model_reset();
    #1;
    check("reset_out_pulse", 32'(out_pulse), 32'd0);
    check("reset_pending",   32'(pending),   32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_overflow",  32'(overflow),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single pulse in cycle 10.
    for (int t = 0; t < 10; t++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int t = 0; t < 10; t++) tick(1'b0, 1'b0);

    // Burst of three back-to-back events.
    for (int t = 0; t < 3; t++) tick(1'b1, 1'b0);
    for (int t = 0; t < 14; t++) tick(1'b0, 1'b0);

    // Random traffic at increasing densities with occasional clears.
    for (int d = 0; d < 4; d++) begin
      for (int t = 0; t < 100; t++) begin
        int pct;
        pct = (d == 0) ? 20 : (d == 1) ? 50 : (d == 2) ? 80 : 95;
        tick(logic'($urandom_range(0, 99) < pct), logic'($urandom_range(0, 99) < 3));
      end
    end
    for (int t = 0; t < 70; t++) tick(1'b0, 1'b0);

    // Fill to PEND_MAX and keep pushing so events are dropped.
    for (int t = 0; t < 30; t++) tick(1'b1, 1'b0);
    check("pending_at_max", 32'(pending), 32'(PEND_MAX));
    // Clear only in cycles where a drop is also predicted: set must win.
    for (int t = 0; t < 8; t++) tick(1'b1, logic'(!model_ready()));
    for (int t = 0; t < 70; t++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);

    // Build up pending=2 in GAP with out_pulse high, then reset mid-cycle.
    for (int t = 0; t < 4; t++) tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("pre_reset_pending", 32'(pending), 32'd2);
    check("pre_reset_out",     32'(out_pulse), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_pulse", 32'(out_pulse), 32'd0);
    check("async_rst_pending",   32'(pending),   32'd0);
    check("async_rst_overflow",  32'(overflow),  32'd0);
    model_reset();
    @(posedge clk);
    m_cyc++;
    #1;
    rst = 1'b0;
    for (int t = 0; t < 20; t++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
